mux16_sync: RTL and testbench

- 16-to-1 selector: picks one of 16 input lanes by a 4-bit select.
- Provides a combinational output and a registered output with a one-cycle latency.
- Used as a bit/lane picker in datapaths that need both a glitch-prone fast path and a clean clocked path.
- A lane is a single bit by default; the lane width is parameterizable.

---
 rtl/mux16_sync.sv | 64 ++++++
 tb/tb_mux16_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux16_sync.sv
// 16-to-1 lane selector with a zero-latency combinational output and a
// one-cycle registered output that also returns the captured select code.
module mux16_sync #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [16*DATA_W-1:0] in,
  input  logic [3:0]          sel,
  input  logic                en,
  output logic [DATA_W-1:0]   q_comb,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic [3:0]          sel_q
);

  logic [DATA_W-1:0] lane [16];

  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] q_next;
  logic [3:0]        sel_q_reg;
  logic [3:0]        sel_q_next;
  logic              q_valid_reg;
  logic              q_valid_next;

  // Lane 0 occupies the least significant DATA_W bits of the packed bus.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign lane[gi] = in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Every 4-bit code addresses a real lane, so no default path exists.
  assign q_comb = lane[sel];

  always_comb begin
    q_next       = q_reg;
    sel_q_next   = sel_q_reg;
    q_valid_next = 1'b0;
    if (en) begin
      q_next       = q_comb;
      sel_q_next   = sel;
      q_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      sel_q_reg   <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      sel_q_reg   <= sel_q_next;
      q_valid_reg <= q_valid_next;
    end
  end

  assign q       = q_reg;
  assign sel_q   = sel_q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_mux16_sync.sv
// Self-checking bench for mux16_sync: directed plan plus random vectors on a
// 1-bit-lane instance and a 4-bit-lane instance, against an arithmetic model.
module tb_mux16_sync;

  logic        clk;
  logic        rst_n;

  logic [15:0] in1;
  logic [3:0]  sel1;
  logic        en1;
  logic        q_comb1;
  logic        q1;
  logic        q_valid1;
  logic [3:0]  sel_q1;

  logic [63:0] inw;
  logic [3:0]  selw;
  logic        enw;
  logic [3:0]  q_combw;
  logic [3:0]  qw;
  logic        q_validw;
  logic [3:0]  sel_qw;

  int vectors;
  int miscompares;

  // Expected register contents for each instance
  logic        m1_q;
  logic [3:0]  m1_sel;
  logic        m1_v;
  logic [3:0]  mw_q;
  logic [3:0]  mw_sel;
  logic        mw_v;

  mux16_sync #(.DATA_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .en(en1),
    .q_comb(q_comb1), .q(q1), .q_valid(q_valid1), .sel_q(sel_q1)
  );

  mux16_sync #(.DATA_W(4)) dutw (
    .clk(clk), .rst_n(rst_n), .in(inw), .sel(selw), .en(enw),
    .q_comb(q_combw), .q(qw), .q_valid(q_validw), .sel_q(sel_qw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref1(input logic [15:0] v, input logic [3:0] s);
    logic [15:0] sh;
    sh = v >> s;
    return sh[0];
  endfunction

  function automatic logic [3:0] ref4(input logic [63:0] v, input logic [3:0] s);
    logic [63:0] sh;
    sh = v >> (32'(s) * 4);
    return sh[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs1(input string tag);
    chk({tag, ".q"}, 64'(q1), 64'(m1_q));
    chk({tag, ".sel_q"}, 64'(sel_q1), 64'(m1_sel));
    chk({tag, ".q_valid"}, 64'(q_valid1), 64'(m1_v));
  endtask

  task automatic chk_regsw(input string tag);
    chk({tag, ".wq"}, 64'(qw), 64'(mw_q));
    chk({tag, ".wsel_q"}, 64'(sel_qw), 64'(mw_sel));
    chk({tag, ".wq_valid"}, 64'(q_validw), 64'(mw_v));
  endtask

  // Drive one vector mid-cycle, check the fast path, then the clocked path.
  task automatic step1(input logic [15:0] i, input logic [3:0] s, input logic e, input string tag);
    @(negedge clk);
    in1 = i; sel1 = s; en1 = e;
    #1;
    chk({tag, ".comb"}, 64'(q_comb1), 64'(ref1(i, s)));
    @(posedge clk);
    if (e) begin
      m1_q = ref1(i, s); m1_sel = s; m1_v = 1'b1;
    end else begin
      m1_v = 1'b0;
    end
    #1;
    chk_regs1(tag);
    $display("step %s in=%h sel=%0d en=%0d q_comb=%0h q=%0h sel_q=%0d q_valid=%0d",
             tag, i, s, e, q_comb1, q1, sel_q1, q_valid1);
  endtask

  task automatic stepw(input logic [63:0] i, input logic [3:0] s, input logic e, input string tag);
    @(negedge clk);
    inw = i; selw = s; enw = e;
    #1;
    chk({tag, ".wcomb"}, 64'(q_combw), 64'(ref4(i, s)));
    @(posedge clk);
    if (e) begin
      mw_q = ref4(i, s); mw_sel = s; mw_v = 1'b1;
    end else begin
      mw_v = 1'b0;
    end
    #1;
    chk_regsw(tag);
    $display("wstep %s in=%h sel=%0d en=%0d q_comb=%0h q=%0h sel_q=%0d q_valid=%0d",
             tag, i, s, e, q_combw, qw, sel_qw, q_validw);
  endtask

  initial begin
    logic [15:0] onehot;
    logic [63:0] ramp;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    in1 = 16'h0004; sel1 = 4'd2; en1 = 1'b0;
    inw = '0; selw = '0; enw = 1'b0;
    m1_q = 1'b0; m1_sel = '0; m1_v = 1'b0;
    mw_q = '0;   mw_sel = '0; mw_v = 1'b0;

    // Reset state; the fast path still works during reset
    #1;
    chk_regs1("reset");
    chk_regsw("reset");
    chk("reset.comb", 64'(q_comb1), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 16; s++) begin
      onehot = 16'h0001 << s;
      step1(onehot, 4'(s), 1'b1, $sformatf("onehot%0d", s));
    end

    for (int s = 0; s < 16; s++) begin
      onehot = ~(16'h0001 << s);
      step1(onehot, 4'(s), 1'b1, $sformatf("onecold%0d", s));
      sel1 = 4'((s + 1) & 15);
      #1;
      chk($sformatf("onecold%0d.nbr", s), 64'(q_comb1), 64'(ref1(onehot, sel1)));
    end

    // Enable hold: captured lane survives en=0 while inputs move
    step1(16'h0020, 4'd5, 1'b1, "hold.cap");
    step1(16'h0000, 4'd3, 1'b0, "hold.off");
    step1(16'hFFFF, 4'd9, 1'b0, "hold.off2");

    // Asynchronous reset between edges
    step1(16'h0001, 4'd0, 1'b1, "arst.pre");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m1_q = 1'b0; m1_sel = '0; m1_v = 1'b0;
    mw_q = '0;   mw_sel = '0; mw_v = 1'b0;
    #1;
    chk_regs1("arst.now");
    in1 = 16'h0100; sel1 = 4'd8; en1 = 1'b1;
    #1;
    chk("arst.comb1", 64'(q_comb1), 64'(1'b1));
    sel1 = 4'd7;
    #1;
    chk("arst.comb0", 64'(q_comb1), 64'(1'b0));
    @(posedge clk);
    #1;
    chk_regs1("arst.held");
    @(negedge clk);
    rst_n = 1'b1;

    // Select and data change together at one edge
    step1(16'h0001, 4'd0, 1'b1, "simul.a");
    step1(16'h8000, 4'd15, 1'b1, "simul.b");

    for (int n = 0; n < 150; n++)
      step1(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $sformatf("rand%0d", n));

    // Wide lanes: lane k holds value k
    for (int k = 0; k < 16; k++) ramp[k*4 +: 4] = 4'(k);
    for (int s = 0; s < 16; s++)
      stepw(ramp, 4'(s), 1'b1, $sformatf("ramp%0d", s));
    for (int n = 0; n < 60; n++)
      stepw({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $sformatf("wrand%0d", n));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
